// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial ripple subtractor:
//   - state_e   : controller states (IDLE, SHIFT, DONE)
//   - WIDTH_MAX : largest supported operand width
//   - idx_width : bit-index counter width, clog2(WIDTH) with a floor of 1
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MAX = 32;

  // WIDTH=1 still needs a 1-bit index so the counter has a legal declaration.
  function automatic int idx_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor: d = a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when a<b outright, or when a==b and a borrow is already pending.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// serial_ripple_subtractor
// Bit-serial subtractor computing diff = a - b - bin, LSB first, one
// full_subtractor stage per clock. A start/busy/done handshake sequences it.
// Optional build macro: SERSUB_SIGNED_OVF_EN adds the signed-overflow port ovf.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   start in  1      request, sampled in IDLE or DONE
//   a     in  WIDTH  minuend, captured on accepted start
//   b     in  WIDTH  subtrahend, captured on accepted start
//   bin   in  1      borrow-in, captured on accepted start
//   busy  out 1      high while operating (registered)
//   done  out 1      one-cycle result-valid pulse (registered)
//   diff  out WIDTH  difference, held until next result
//   bout  out 1      borrow-out of the MSB stage, held with diff
//   ovf   out 1      signed overflow (SERSUB_SIGNED_OVF_EN only)
// busy/done are registered from the state, so they trail it by one cycle:
// start accepted at edge T gives busy after edges T+1..T+WIDTH and done after
// edge T+WIDTH+1. diff/bout are loaded as the state enters DONE.
// Legal WIDTH range: 1..WIDTH_MAX.
// -----------------------------------------------------------------------------
module serial_ripple_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
`ifdef SERSUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state and datapath: capture on start, one bit per SHIFT cycle.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    shadow_d = shadow_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    br_d     = br_q;
    bout_d   = bout_q;
    busy_d   = (state_q == SHIFT);
    done_d   = (state_q == DONE);
`ifdef SERSUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          br_d     = bin;
          idx_d    = {IDX_W{1'b0}};
          shadow_d = {WIDTH{1'b0}};
`ifdef SERSUB_SIGNED_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        br_d     = fs_bout;
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        shadow_d = shadow_q >> 1;
        shadow_d[WIDTH-1] = fs_d;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // Publish straight from the completed shadow value so diff never
          // shows a partial result.
          diff_d  = shadow_d;
          bout_d  = fs_bout;
`ifdef SERSUB_SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) & (fs_d != a_msb_q);
`endif
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      shadow_q <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      br_q     <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      shadow_q <= shadow_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      br_q     <= br_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERSUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERSUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
